seq_det_scheduler: RTL and testbench

//  Shares one Mealy pattern-detector step (seq_det_core) among NCH serial bit streams.
//  - Round-robin arbiter accepts at most one bit per cycle.
//  - Each channel's partial-match state is kept in a per-channel context register.
//  - The hit result is reported tagged with its channel.
//  - Sits between the serial front-ends and the event logic; replaces NCH separate detectors.

---
 rtl/seq_det_pkg.sv | 39 +++
 rtl/seq_det_scheduler_if.sv | 32 +++
 rtl/seq_det_core.sv | 31 +++
 rtl/seq_det_scheduler.sv | 179 +++++++++++++++++
 tb/tb_seq_det_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the multi-channel sequence detector.
// PAT_W lives here because the per-channel context type is sized from it.
package seq_det_pkg;

    // Pattern length in bits.
    localparam int PAT_W = 3;

    // Hit counter width.
    localparam int CNT_W = 16;

    // Ceiling log2, at least 1, used for channel-index and fill widths.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int FILL_W = clog2(PAT_W);

    // Power-up pattern: 3'b001 zero-extended to PAT_W.
    localparam logic [PAT_W-1:0] DEF_PATTERN = {{(PAT_W-1){1'b0}}, 1'b1};

    // Saturation value for the fill level.
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-channel partial-match context: recent bits (newest in LSB) and fill level.
    typedef struct packed {
        logic [PAT_W-2:0]  hist;
        logic [FILL_W-1:0] fill;
    } ctx_t;

    localparam ctx_t CTX_RESET = '{hist: {(PAT_W-1){1'b0}}, fill: {FILL_W{1'b0}}};

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Channel, configuration and result bus of the shared sequence detector.
// master: serial front-ends / event logic side; slave: the scheduler.
interface seq_det_scheduler_if
    import seq_det_pkg::*;
#(
    parameter int NCH = 4
) ();
    localparam int CH_W = clog2(NCH);

    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_din;
    logic [NCH-1:0]   ch_ready;
    logic [NCH-1:0]   ch_clr;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic             det_valid;
    logic [CH_W-1:0]  det_ch;
    logic             det_hit;
    logic [CH_W-1:0]  cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output ch_valid, ch_din, ch_clr, cfg_we, cfg_pattern, cnt_sel,
        input  ch_ready, det_valid, det_ch, det_hit, cnt_out
    );

    modport slave (
        input  ch_valid, ch_din, ch_clr, cfg_we, cfg_pattern, cnt_sel,
        output ch_ready, det_valid, det_ch, det_hit, cnt_out
    );

endinterface

// File: rtl/seq_det_core.sv
// One combinational step of the Mealy pattern detector, applied to whichever
// channel context the scheduler selects this cycle.
module seq_det_core
    import seq_det_pkg::*;
(
    input  ctx_t             i_ctx,
    input  logic             i_din,
    input  logic [PAT_W-1:0] i_pattern,
    output ctx_t             o_ctx_next,
    output logic             o_hit
);

    // Window of the last PAT_W bits including the incoming one; MSB is oldest.
    logic [PAT_W-1:0] w_window;
    assign w_window = {i_ctx.hist, i_din};

    // Shift history, saturate fill, flag a hit only once enough bits were seen.
    always_comb begin
        o_ctx_next      = i_ctx;
        o_ctx_next.hist = w_window[PAT_W-2:0];
        o_hit           = 1'b0;
        if (i_ctx.fill == FILL_MAX) begin
            o_ctx_next.fill = i_ctx.fill;
            o_hit           = (w_window == i_pattern);
        end else begin
            o_ctx_next.fill = i_ctx.fill + FILL_W'(1);
            o_hit           = 1'b0;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one seq_det_core among NCH serial channels.
// Optional feature macro: HIT_COUNT_EN (per-channel saturating hit counters).
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                clk,
    input  logic                reset,
    seq_det_scheduler_if.slave  bus
);
    localparam int              CH_W    = clog2(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
    localparam logic [CH_W:0]   NCH_EXT = (CH_W+1)'(NCH);

    logic [PAT_W-1:0] r_pattern;
    logic [CH_W-1:0]  r_ptr;
    ctx_t             r_ctx [NCH];
    logic             r_det_valid;
    logic [CH_W-1:0]  r_det_ch;
    logic             r_det_hit;

    logic             w_grant_any;
    logic [CH_W-1:0]  w_grant_ch;
    logic [NCH-1:0]   w_grant_vec;
    logic [CH_W:0]    w_sum;
    logic [CH_W-1:0]  w_cand;
    ctx_t             w_ctx_next;
    logic             w_hit;

    // Round-robin search from r_ptr upward; cleared channels and config writes block grants.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_ch  = {CH_W{1'b0}};
        w_grant_vec = {NCH{1'b0}};
        w_sum       = {(CH_W+1){1'b0}};
        w_cand      = {CH_W{1'b0}};
        if (bus.cfg_we == 1'b0) begin
            for (int k = 0; k < NCH; k++) begin
                w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
                if (w_sum >= NCH_EXT) begin
                    w_sum = w_sum - NCH_EXT;
                end else begin
                    w_sum = w_sum;
                end
                w_cand = w_sum[CH_W-1:0];
                if (!w_grant_any && bus.ch_valid[w_cand] && !bus.ch_clr[w_cand]) begin
                    w_grant_any = 1'b1;
                    w_grant_ch  = w_cand;
                end else begin
                    w_grant_any = w_grant_any;
                end
            end
            if (w_grant_any) begin
                w_grant_vec[w_grant_ch] = 1'b1;
            end else begin
                w_grant_vec = {NCH{1'b0}};
            end
        end else begin
            w_grant_any = 1'b0;
        end
    end

    assign bus.ch_ready = w_grant_vec;

    seq_det_core u_core (
        .i_ctx      (r_ctx[w_grant_ch]),
        .i_din      (bus.ch_din[w_grant_ch]),
        .i_pattern  (r_pattern),
        .o_ctx_next (w_ctx_next),
        .o_hit      (w_hit)
    );

    // Pattern register, loaded by a configuration write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= DEF_PATTERN;
        end else if (bus.cfg_we) begin
            r_pattern <= bus.cfg_pattern;
        end else begin
            r_pattern <= r_pattern;
        end
    end

    // Round-robin pointer moves just past the granted channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= {CH_W{1'b0}};
        end else if (w_grant_any) begin
            r_ptr <= (w_grant_ch == LAST_CH) ? {CH_W{1'b0}} : (w_grant_ch + CH_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Per-channel contexts: config write clears all, ch_clr clears one, grant advances one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= CTX_RESET;
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= CTX_RESET;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    r_ctx[i] <= CTX_RESET;
                end else if (w_grant_vec[i]) begin
                    r_ctx[i] <= w_ctx_next;
                end else begin
                    r_ctx[i] <= r_ctx[i];
                end
            end
        end
    end

    // Detection result one cycle after acceptance; channel and hit hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_det_valid <= 1'b0;
            r_det_ch    <= {CH_W{1'b0}};
            r_det_hit   <= 1'b0;
        end else if (w_grant_any) begin
            r_det_valid <= 1'b1;
            r_det_ch    <= w_grant_ch;
            r_det_hit   <= w_hit;
        end else begin
            r_det_valid <= 1'b0;
            r_det_ch    <= r_det_ch;
            r_det_hit   <= r_det_hit;
        end
    end

    assign bus.det_valid = r_det_valid;
    assign bus.det_ch    = r_det_ch;
    assign bus.det_hit   = r_det_hit;

`ifdef HIT_COUNT_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    // Saturating per-channel hit counters, cleared with their context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else if (w_grant_vec[i] && w_hit && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Combinational counter read; unmapped selects read as zero.
    always_comb begin
        bus.cnt_out = {CNT_W{1'b0}};
        if (int'(bus.cnt_sel) < NCH) begin
            bus.cnt_out = r_cnt[bus.cnt_sel];
        end else begin
            bus.cnt_out = {CNT_W{1'b0}};
        end
    end
`else
    assign bus.cnt_out = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: directed scenarios followed by
// random traffic, all compared against a bit-queue reference model.
module tb_seq_det_scheduler;
    import seq_det_pkg::*;

    localparam int NCH  = 4;
    localparam int CH_W = clog2(NCH);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seq_det_scheduler_if #(.NCH(NCH)) bus ();

    seq_det_scheduler #(.NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    int               m_ptr;
    logic [PAT_W-1:0] m_pat;
    bit               mq [NCH][$];
    int               m_cnt [NCH];
    logic             m_dv;
    int               m_dch;
    logic             m_dhit;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int sel);
`ifdef HIT_COUNT_EN
        return m_cnt[sel];
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_pat  = DEF_PATTERN;
        m_dv   = 1'b0;
        m_dch  = 0;
        m_dhit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_det_valid"}, 32'(bus.det_valid), 32'(m_dv));
        chk({pfx, "_det_ch"},    32'(bus.det_ch),    32'(m_dch));
        chk({pfx, "_det_hit"},   32'(bus.det_hit),   32'(m_dhit));
        chk({pfx, "_cnt_out"},   32'(bus.cnt_out),   32'(exp_cnt(int'(bus.cnt_sel))));
    endtask

    // Entered at posedge+1; applies one cycle of inputs and checks grant and result.
    task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] d,
                         input logic [NCH-1:0] c, input logic we,
                         input logic [PAT_W-1:0] pat, input logic [CH_W-1:0] sel);
        bit               g_any;
        int               g;
        int               idx;
        int               sz;
        logic [PAT_W-1:0] win;
        logic             hit;
        logic [NCH-1:0]   exp_ready;
        bus.ch_valid    = v;
        bus.ch_din      = d;
        bus.ch_clr      = c;
        bus.cfg_we      = we;
        bus.cfg_pattern = pat;
        bus.cnt_sel     = sel;
        g_any = 1'b0;
        g     = 0;
        if (!we) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_ptr + k) % NCH;
                if (!g_any && v[idx] && !c[idx]) begin
                    g_any = 1'b1;
                    g     = idx;
                end
            end
        end
        exp_ready = '0;
        if (g_any) exp_ready[g] = 1'b1;
        @(negedge clk);
        chk("ch_ready", 32'(bus.ch_ready), 32'(exp_ready));
        m_dv = g_any;
        if (g_any) begin
            sz  = mq[g].size();
            hit = 1'b0;
            if (sz >= PAT_W - 1) begin
                win    = '0;
                win[0] = d[g];
                for (int j = 1; j < PAT_W; j++) win[j] = mq[g][sz - j];
                hit = (win == m_pat);
            end
            mq[g].push_back(d[g]);
            if (mq[g].size() > 8) void'(mq[g].pop_front());
            if (hit && m_cnt[g] < 65535) m_cnt[g]++;
            m_dch  = g;
            m_dhit = hit;
            m_ptr  = (g + 1) % NCH;
        end
        if (we) begin
            m_pat = pat;
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                m_cnt[i] = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (c[i]) begin
                mq[i].delete();
                m_cnt[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset, held across one edge; returns at posedge+1.
    task automatic apply_reset();
        bus.ch_valid    = '0;
        bus.ch_din      = '0;
        bus.ch_clr      = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cnt_sel     = '0;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_idle");
    endtask

    initial begin
        logic [NCH-1:0] rv, rd, rc;
        logic           rwe;
        logic [PAT_W-1:0] rpat;
        logic [CH_W-1:0]  rsel;
        #2;
        apply_reset();

        // 1: ch0 alone streams 0,0,1,0,0,1 at full rate
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t1_hit3", 32'(bus.det_hit), 32'd1);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t1_hit6", 32'(bus.det_hit), 32'd1);

        // 2: ch0 = 0,0,1 and ch1 = 0,1,1, both always valid, from ptr 0
        apply_reset();
        cycle(4'b0011, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0011, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd1);
        cycle(4'b0011, 4'b0010, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0011, 4'b0010, 4'b0000, 1'b0, 3'b000, 2'd1);
        cycle(4'b0011, 4'b0011, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t2_ch0_hit", 32'(bus.det_hit), 32'd1);
        cycle(4'b0011, 4'b0011, 4'b0000, 1'b0, 3'b000, 2'd1);
        chk("t2_ch1_nohit", 32'(bus.det_hit), 32'd0);

        // 3: all four valid starting at ptr 2
        for (int i = 0; i < 4; i++) cycle(4'b1111, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);

        // 4: clear of ch0 blocks its grant and drops its history; ch1 untouched
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0010, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd1);
        cycle(4'b0010, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd1);
        cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t4_no_hit_after_clr", 32'(bus.det_hit), 32'd0);
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, 3'b000, 2'd1);
        chk("t4_ch1_hit", 32'(bus.det_hit), 32'd1);

        // 5: load pattern 110 while ch0 requests, then stream 1,1,0
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b1, 3'b110, 2'd0);
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t5_hit_110", 32'(bus.det_hit), 32'd1);

        // 6: reset after 0,0 (default pattern restored), then 1 must not hit
        apply_reset();
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 3'b000, 2'd0);
        apply_reset();
        cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 3'b000, 2'd0);
        chk("t6_no_hit_after_rst", 32'(bus.det_hit), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rv   = NCH'($urandom);
            rd   = NCH'($urandom);
            rc   = '0;
            if ($urandom_range(0, 9) == 0) rc[$urandom_range(0, NCH - 1)] = 1'b1;
            rwe  = ($urandom_range(0, 49) == 0);
            rpat = PAT_W'($urandom);
            rsel = CH_W'($urandom);
            cycle(rv, rd, rc, rwe, rpat, rsel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
